// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests to imem,
// buffers in-order responses and hands {instr, pc, pc+4} to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   ipc_q  [DEPTH];
  logic [31:0]   ipc_d  [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [31:0]   pc_q, pc_d;
  logic          run_q, run_d;

  logic          req_fire, rsp_fire, push, pop, fifo_empty;
  logic [SW-1:0] credit_used;
  logic [31:0]   rsp_pc;

  // Outstanding requests were issued back to back, so the oldest kept one sits
  // exactly outst_q words behind the fetch PC once all dropped ones have drained.
  assign rsp_pc      = pc_q - (32'(outst_q) << 2);
  assign fifo_empty  = (count_q == '0);
  assign credit_used = SW'(count_q) + SW'(outst_q);

  assign imem_req_valid = run_q & ~redirect_valid & (credit_used < SW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign instr_valid    = ~fifo_empty & ~redirect_valid;
  assign instr          = fifo_empty ? 32'd0 : data_q[rd_ptr_q];
  assign instr_pc       = fifo_empty ? 32'd0 : ipc_q[rd_ptr_q];
  assign pc_plus4       = fifo_empty ? 32'd0 : ipc_q[rd_ptr_q] + 32'd4;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & (outst_q != '0);
  assign push     = rsp_fire & (drop_q == '0) & ~redirect_valid;
  assign pop      = instr_valid & instr_ready;

  always_comb begin
    data_d   = data_q;
    ipc_d    = ipc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    pc_d     = pc_q;
    run_d    = 1'b1;
    outst_d  = outst_q + CW'(req_fire) - CW'(rsp_fire);
    if (req_fire) pc_d = pc_q + 32'd4;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old stream.
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = outst_d;
    end else begin
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        data_d[wr_ptr_q] = imem_rsp_data;
        ipc_d[wr_ptr_q]  = rsp_pc;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      pc_q     <= RESET_PC;
      run_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      ipc_q    <= ipc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      pc_q     <= pc_d;
      run_q    <= run_d;
    end
  end

endmodule
